// File: rtl/gpr_file_param_pkg.sv
// Shared definitions for the parameterised register file: write-operation encodings.
package gpr_file_param_pkg;

    typedef enum logic [1:0] {
        WR_LOAD = 2'b00,
        WR_ADD  = 2'b01,
        WR_SUB  = 2'b10,
        WR_CLR  = 2'b11
    } wr_mode_e;

    // Only arithmetic writes touch the flags; LOAD/CLR keep the previous ones.
    function automatic logic is_arith(wr_mode_e mode);
        return (mode == WR_ADD) || (mode == WR_SUB);
    endfunction

endpackage

// File: rtl/gpr_file_param_if.sv
// Bus bundle for the register file: write, two read ports, reservation and flags.
interface gpr_file_param_if
    import gpr_file_param_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    wr_mode_e          wr_mode;
    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              busy_a;
    logic              busy_b;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              rsv_err;
    logic              flag_c;
    logic              flag_z;
    logic              flag_v;

    modport master (
        output wr_en, wr_addr, wr_data, wr_mode,
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output rsv_en, rsv_addr,
        input  rd_data_a, rd_data_b, busy_a, busy_b, rsv_err,
        input  flag_c, flag_z, flag_v
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_mode,
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  rsv_en, rsv_addr,
        output rd_data_a, rd_data_b, busy_a, busy_b, rsv_err,
        output flag_c, flag_z, flag_v
    );

endinterface

// File: rtl/gpr_alu_update.sv
// Combinational next-value and flag computation for one register write.
module gpr_alu_update
    import gpr_file_param_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] old_val,
    input  logic [DATA_W-1:0] operand,
    input  wr_mode_e          mode,
    output logic [DATA_W-1:0] result,
    output logic              c,
    output logic              z,
    output logic              v
);
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, old_val} + {1'b0, operand};
    assign diff = {1'b0, old_val} - {1'b0, operand};

    // For SUB the extra top bit of the widened difference is the borrow.
    always_comb begin
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (mode)
            WR_LOAD: result = operand;
            WR_ADD: begin
                result = sum[DATA_W-1:0];
                c      = sum[DATA_W];
                v      = (old_val[DATA_W-1] == operand[DATA_W-1]) &&
                         (result[DATA_W-1] != old_val[DATA_W-1]);
            end
            WR_SUB: begin
                result = diff[DATA_W-1:0];
                c      = diff[DATA_W];
                v      = (old_val[DATA_W-1] != operand[DATA_W-1]) &&
                         (result[DATA_W-1] != old_val[DATA_W-1]);
            end
            default: result = '0;
        endcase
    end

    assign z = (result == '0);

endmodule

// File: rtl/gpr_file_param.sv
// Register file with LOAD/ADD/SUB/CLR writes, two combinational read ports and a busy scoreboard.
module gpr_file_param
    import gpr_file_param_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8
) (
    input logic          clk,
    input logic          rst,
    gpr_file_param_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [ADDR_W-1:0]   wr_idx, rsv_idx, rd_idx_a, rd_idx_b;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_c, alu_z, alu_v;
    logic                flag_c_q, flag_z_q, flag_v_q, rsv_err_q;

    assign wr_idx   = bus.wr_addr;
    assign rsv_idx  = bus.rsv_addr;
    assign rd_idx_a = bus.rd_addr_a;
    assign rd_idx_b = bus.rd_addr_b;

    gpr_alu_update #(.DATA_W(DATA_W)) u_alu (
        .old_val (regs[wr_idx]),
        .operand (bus.wr_data),
        .mode    (bus.wr_mode),
        .result  (alu_result),
        .c       (alu_c),
        .z       (alu_z),
        .v       (alu_v)
    );

    // Reservation is applied after the write clear so it wins on an address clash.
    always_comb begin
        busy_next = busy;
        if (bus.wr_en)  busy_next[wr_idx]  = 1'b0;
        if (bus.rsv_en) busy_next[rsv_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            busy      <= '0;
            flag_c_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_v_q  <= 1'b0;
            rsv_err_q <= 1'b0;
        end else begin
            if (bus.wr_en) regs[wr_idx] <= alu_result;
            if (bus.wr_en && is_arith(bus.wr_mode)) begin
                flag_c_q <= alu_c;
                flag_z_q <= alu_z;
                flag_v_q <= alu_v;
            end
            busy      <= busy_next;
            rsv_err_q <= bus.rsv_en && busy[rsv_idx];
        end
    end

    assign bus.rd_data_a = bus.rd_en_a ? regs[rd_idx_a] : '0;
    assign bus.rd_data_b = bus.rd_en_b ? regs[rd_idx_b] : '0;
    assign bus.busy_a    = busy[rd_idx_a];
    assign bus.busy_b    = busy[rd_idx_b];
    assign bus.rsv_err   = rsv_err_q;
    assign bus.flag_c    = flag_c_q;
    assign bus.flag_z    = flag_z_q;
    assign bus.flag_v    = flag_v_q;

endmodule

// File: tb/tb_gpr_file_param.sv
// Scoreboard bench for gpr_file_param: directed scenarios plus random traffic against an integer model.
module tb_gpr_file_param;
    import gpr_file_param_pkg::*;

    localparam int DW = 16;
    localparam int NR = 8;
    localparam int AW = 3;
    localparam int MODV = 1 << DW;

    typedef struct {
        logic          wr_en;
        logic [1:0]    mode;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          rd_en_a;
        logic [AW-1:0] rd_addr_a;
        logic          rd_en_b;
        logic [AW-1:0] rd_addr_b;
        logic          rsv_en;
        logic [AW-1:0] rsv_addr;
    } stim_t;

    typedef struct {
        string         tag;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          ba, bb, err, c, z, v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gpr_file_param_if #(.DATA_W(DW), .ADDR_W(AW)) ifc ();

    gpr_file_param #(.DATA_W(DW), .NUM_REGS(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];
    event obs_ev;

    // Reference model: plain integers, updated once per clocked cycle
    int unsigned m_regs [NR];
    bit          m_busy [NR];
    bit          m_c, m_z, m_v, m_err;

    function automatic stim_t mk(bit we, int mode, int wa, int wd,
                                 bit ea, int ra, bit eb, int rb, bit re, int rsa);
        stim_t s;
        s.wr_en = we; s.mode = mode[1:0]; s.wr_addr = wa[AW-1:0]; s.wr_data = wd[DW-1:0];
        s.rd_en_a = ea; s.rd_addr_a = ra[AW-1:0]; s.rd_en_b = eb; s.rd_addr_b = rb[AW-1:0];
        s.rsv_en = re; s.rsv_addr = rsa[AW-1:0];
        return s;
    endfunction

    function automatic int to_signed(int unsigned x);
        return (x >= MODV / 2) ? int'(x) - MODV : int'(x);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = 0;
            m_busy[i] = 1'b0;
        end
        m_c = 1'b0; m_z = 1'b0; m_v = 1'b0; m_err = 1'b0;
    endtask

    task automatic push_expect(string tag, stim_t s);
        exp_t e;
        e.tag = tag;
        e.a   = s.rd_en_a ? m_regs[s.rd_addr_a][DW-1:0] : '0;
        e.b   = s.rd_en_b ? m_regs[s.rd_addr_b][DW-1:0] : '0;
        e.ba  = m_busy[s.rd_addr_a];
        e.bb  = m_busy[s.rd_addr_b];
        e.err = m_err; e.c = m_c; e.z = m_z; e.v = m_v;
        exp_q.push_back(e);
        -> obs_ev;
    endtask

    task automatic model_step(stim_t s);
        int unsigned o, d;
        int full, sres;
        bit hit_busy;
        hit_busy = s.rsv_en && m_busy[s.rsv_addr];
        if (s.wr_en) begin
            o = m_regs[s.wr_addr];
            d = s.wr_data;
            case (s.mode)
                2'b00: m_regs[s.wr_addr] = d;
                2'b01: begin
                    full = int'(o) + int'(d);
                    m_regs[s.wr_addr] = full % MODV;
                    m_c = full >= MODV;
                    sres = to_signed(o) + to_signed(d);
                    m_v = (sres > MODV / 2 - 1) || (sres < -(MODV / 2));
                    m_z = (full % MODV) == 0;
                end
                2'b10: begin
                    full = int'(o) - int'(d);
                    m_regs[s.wr_addr] = (full + MODV) % MODV;
                    m_c = full < 0;
                    sres = to_signed(o) - to_signed(d);
                    m_v = (sres > MODV / 2 - 1) || (sres < -(MODV / 2));
                    m_z = ((full + MODV) % MODV) == 0;
                end
                default: m_regs[s.wr_addr] = 0;
            endcase
            m_busy[s.wr_addr] = 1'b0;
        end
        if (s.rsv_en) m_busy[s.rsv_addr] = 1'b1;
        m_err = hit_busy;
    endtask

    task automatic drive(stim_t s);
        ifc.wr_en     = s.wr_en;
        ifc.wr_mode   = wr_mode_e'(s.mode);
        ifc.wr_addr   = s.wr_addr;
        ifc.wr_data   = s.wr_data;
        ifc.rd_en_a   = s.rd_en_a;
        ifc.rd_addr_a = s.rd_addr_a;
        ifc.rd_en_b   = s.rd_en_b;
        ifc.rd_addr_b = s.rd_addr_b;
        ifc.rsv_en    = s.rsv_en;
        ifc.rsv_addr  = s.rsv_addr;
    endtask

    // One clocked cycle: drive after the falling edge, expect pre-edge outputs, then advance the model.
    task automatic cyc(string tag, stim_t s);
        @(negedge clk);
        drive(s);
        #1;
        push_expect(tag, s);
        model_step(s);
    endtask

    task automatic cmp(string tag, string field, logic [DW-1:0] act, logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h at %0t", tag, field, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per observation and compares all visible outputs
    initial begin
        exp_t e;
        forever begin
            @(obs_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp(e.tag, "rd_data_a", ifc.rd_data_a, e.a);
                cmp(e.tag, "rd_data_b", ifc.rd_data_b, e.b);
                cmp(e.tag, "busy_a", DW'(ifc.busy_a), DW'(e.ba));
                cmp(e.tag, "busy_b", DW'(ifc.busy_b), DW'(e.bb));
                cmp(e.tag, "rsv_err", DW'(ifc.rsv_err), DW'(e.err));
                cmp(e.tag, "flag_c", DW'(ifc.flag_c), DW'(e.c));
                cmp(e.tag, "flag_z", DW'(ifc.flag_z), DW'(e.z));
                cmp(e.tag, "flag_v", DW'(ifc.flag_v), DW'(e.v));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        model_reset();
        drive(mk(0, 0, 0, 0, 1, 3, 0, 3, 0, 0));
        #3;
        push_expect("reset", mk(0, 0, 0, 0, 1, 3, 0, 3, 0, 0));
        @(negedge clk);
        rst = 1'b1;

        cyc("load_r3", mk(1, 0, 3, 'hA5A5, 1, 3, 0, 3, 0, 0));
        cyc("read_r3", mk(0, 0, 0, 0, 1, 3, 0, 3, 0, 0));

        cyc("ld_r1", mk(1, 0, 1, 'hFFFF, 0, 0, 0, 0, 0, 0));
        cyc("add_r1", mk(1, 1, 1, 'h0001, 1, 1, 0, 0, 0, 0));
        cyc("chk_add", mk(0, 0, 0, 0, 1, 1, 1, 3, 0, 0));
        cyc("sub_r1", mk(1, 2, 1, 'h0001, 1, 1, 0, 0, 0, 0));
        cyc("chk_sub", mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));

        cyc("ld_r2", mk(1, 0, 2, 'h7FFF, 0, 0, 0, 0, 0, 0));
        cyc("add_r2", mk(1, 1, 2, 'h0001, 0, 0, 1, 2, 0, 0));
        cyc("chk_ovf", mk(1, 0, 2, 'h1234, 1, 2, 0, 0, 0, 0));
        cyc("chk_ld", mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 0));

        cyc("ld_r4_same", mk(1, 0, 4, 'hBEEF, 1, 4, 1, 4, 0, 0));
        cyc("rd_r4_after", mk(0, 0, 0, 0, 1, 4, 0, 0, 0, 0));

        cyc("rsv_r5", mk(0, 0, 0, 0, 1, 5, 0, 5, 1, 5));
        cyc("rsv_r5_again", mk(0, 0, 0, 0, 1, 5, 0, 5, 1, 5));
        cyc("err_pulse", mk(0, 0, 0, 0, 1, 5, 0, 5, 0, 0));
        cyc("err_gone", mk(0, 0, 0, 0, 1, 5, 0, 5, 0, 0));
        cyc("rsv_wr_r5", mk(1, 0, 5, 'h0055, 1, 5, 0, 5, 1, 5));
        cyc("rsv_wins", mk(0, 0, 0, 0, 1, 5, 0, 5, 0, 0));
        cyc("wr_r5", mk(1, 0, 5, 'h0066, 1, 5, 0, 5, 0, 0));
        cyc("busy_clear", mk(0, 0, 0, 0, 1, 5, 1, 5, 0, 0));

        for (int i = 0; i < 400; i++) begin
            s = mk($urandom_range(0, 9) < 6, $urandom_range(0, 3), $urandom_range(0, NR - 1),
                   $urandom_range(0, MODV - 1), $urandom_range(0, 3) != 0, $urandom_range(0, NR - 1),
                   $urandom_range(0, 3) != 0, $urandom_range(0, NR - 1),
                   $urandom_range(0, 4) == 0, $urandom_range(0, NR - 1));
            if ($urandom_range(0, 7) == 0) s.wr_data = (s.mode == 2'b01) ? 16'hFFFF : 16'h8000;
            cyc("random", s);
        end

        // Leave flags, busy bits and data non-zero before the asynchronous reset
        cyc("pre_ld", mk(1, 0, 1, 'hFFFF, 0, 0, 0, 0, 0, 0));
        cyc("pre_add", mk(1, 1, 1, 'h0001, 0, 0, 0, 0, 1, 2));
        cyc("pre_ld3", mk(1, 0, 3, 'h1111, 1, 1, 1, 2, 0, 0));
        cyc("pre_chk", mk(0, 0, 0, 0, 1, 3, 1, 2, 0, 0));

        @(negedge clk);
        s = mk(1, 0, 6, 'hFACE, 1, 3, 1, 2, 1, 2);
        drive(s);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        push_expect("async_rst", s);
        s = mk(1, 0, 6, 'hFACE, 1, 6, 1, 1, 1, 2);
        drive(s);
        #1;
        push_expect("rst_hold", s);
        @(posedge clk);
        #1;
        push_expect("rst_edge", s);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        cyc("post_rst6", mk(0, 0, 0, 0, 1, 6, 1, 3, 0, 0));
        cyc("post_rst12", mk(0, 0, 0, 0, 1, 1, 1, 2, 0, 0));
        cyc("post_rst_wr", mk(1, 0, 6, 'h0F0F, 1, 6, 0, 0, 0, 0));
        cyc("post_rst_rd", mk(0, 0, 0, 0, 1, 6, 0, 0, 0, 0));

        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpr_file_param.md
GPR_FILE_PARAM -- requirements
Module: gpr_file_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of every register and data port.
REQ-002 SHALL have parameter NUM_REGS, default 8: register count, power of two, at least 2.
REQ-003 SHALL have derived parameter ADDR_W = clog2(NUM_REGS): width of every address port.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports wr_en, wr_addr, wr_data  in  1 / ADDR_W / DATA_W  write request, target register, operand.
REQ-007 SHALL have port wr_mode  in  2  write operation: 00 LOAD, 01 ADD, 10 SUB, 11 CLR.
REQ-008 SHALL have ports rd_en_a, rd_addr_a  in  1 / ADDR_W  read port A request; rd_en_b, rd_addr_b the same for port B.
REQ-009 SHALL have ports rd_data_a, rd_data_b  out  DATA_W  combinational read data.
REQ-010 SHALL have ports busy_a, busy_b  out  1  scoreboard bit of the register addressed by each read port.
REQ-011 SHALL have ports rsv_en, rsv_addr  in  1 / ADDR_W  reserve a register as pending-write.
REQ-012 SHALL have port rsv_err  out  1  registered one-cycle pulse for a reservation of an already-busy register.
REQ-013 SHALL have ports flag_c, flag_z, flag_v  out  1  carry, zero and signed-overflow flags of the last ADD/SUB.

Function
REQ-014 SHALL return regs[rd_addr_x] on rd_data_x when rd_en_x=1, and all zeros when rd_en_x=0.
REQ-015 SHALL return the pre-edge (old) value on a read of an address being written in the same cycle; no forwarding.
REQ-016 SHALL update regs[wr_addr] on a wr_en=1 edge: LOAD gives wr_data, ADD gives reg+wr_data, SUB gives reg-wr_data, CLR gives 0; results wrap modulo 2^DATA_W.
REQ-017 SHALL register the flags on ADD/SUB only: C = carry-out (ADD) or borrow (SUB), Z = result==0, V = two's-complement overflow; LOAD/CLR leave the flags unchanged.
REQ-018 SHALL keep one busy bit per register: rsv_en=1 sets busy[rsv_addr], wr_en=1 clears busy[wr_addr].
REQ-019 SHALL leave busy set when rsv and wr hit the same address in the same cycle (reservation wins).
REQ-020 SHALL pulse rsv_err for exactly one cycle after rsv_en targets a register already busy; busy stays set.
REQ-021 SHALL drive busy_a/busy_b combinationally from busy[rd_addr_x], regardless of rd_en_x.
REQ-022 SHALL ignore an out-of-range address: no such case exists, since NUM_REGS is a power of two.

Reset
REQ-023 SHALL, while rst=0, clear immediately all registers, all busy bits, flag_c, flag_z, flag_v and rsv_err, independent of clk.
REQ-024 SHALL discard a write or reservation coincident with reset assertion; the first update occurs on the first rising edge with rst=1.

Structure
REQ-025 SHALL define the wr_mode encodings (LOAD/ADD/SUB/CLR) as named constants in the shared processor package.
REQ-026 SHALL isolate the ADD/SUB/flag logic in one sub-module, gpr_alu_update (combinational: old value, operand, mode -> result, C, Z, V).
REQ-027 SHALL hold storage, scoreboard and read muxing in gpr_file_param; no latches; reads purely combinational.

Verification
REQ-028 SHALL verify reset then LOAD 0xA5A5 to r3 and read r3 on port A -> rd_data_a=0xA5A5, with port B disabled returning 0x0000.
REQ-029 SHALL verify r1=0xFFFF, ADD 0x0001 -> r1=0x0000, C=1, Z=1, V=0; then SUB 0x0001 -> r1=0xFFFF, C=1 (borrow), Z=0.
REQ-030 SHALL verify r2=0x7FFF, ADD 0x0001 -> r2=0x8000, V=1, C=0; then LOAD 0x1234 -> flags unchanged.
REQ-031 SHALL verify a same-cycle LOAD 0xBEEF to r4 with a read of r4 -> pre-edge value during the cycle, 0xBEEF after the edge.
REQ-032 SHALL verify rsv r5 -> busy_a=1; rsv r5 again -> rsv_err pulse of one cycle; rsv+write r5 together -> busy stays 1; write r5 alone -> busy_a=0.
REQ-033 SHALL verify rst=0 asserted mid-cycle during a LOAD 0xFACE -> all registers, busy bits and flags 0 immediately, with no write after rst=1.
